// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// slave = arbiter side, master = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   REQ_VALID;
   logic [N_REQ-1:0]   REQ_READY;
   logic [8*N_REQ-1:0] REQ_DATA;
   logic [N_REQ-1:0]   REQ_PAR_EN;
   logic [N_REQ-1:0]   REQ_PAR_TYP;
   logic               TX_BUSY;
   logic [7:0]         P_DATA;
   logic               PAR_EN;
   logic               PAR_TYP;
   logic               DATA_VALID;
   logic [2:0]         GRANT_ID;
   logic               ACTIVE;

   modport slave (
      input  REQ_VALID, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, TX_BUSY,
      output REQ_READY, P_DATA, PAR_EN, PAR_TYP, DATA_VALID,
      output GRANT_ID, ACTIVE
   );

   modport master (
      output REQ_VALID, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, TX_BUSY,
      input  REQ_READY, P_DATA, PAR_EN, PAR_TYP, DATA_VALID,
      input  GRANT_ID, ACTIVE
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ
// byte requesters; holds the winner's frame config until Busy drops.
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int MIN_GAP = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   uart_tx_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic       pen_q, pen_d;
   logic       ptyp_q, ptyp_d;
   logic       dv_q, dv_d;
   logic [2:0] gid_q, gid_d;
   logic [2:0] last_q, last_d;
   logic [7:0] gap_q, gap_d;

   logic [7:0]  vld8, pen8, ptyp8;
   logic [63:0] data64;
   logic        found;
   logic [2:0]  win;
   logic [3:0]  idx;
   logic        grant_ok;

   assign vld8   = 8'(bus.REQ_VALID);
   assign pen8   = 8'(bus.REQ_PAR_EN);
   assign ptyp8  = 8'(bus.REQ_PAR_TYP);
   assign data64 = 64'(bus.REQ_DATA);

   // Search begins one past the last grant and wraps modulo N_REQ.
   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      idx   = 4'd0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = 4'(last_q) + 4'(k);
         if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
         if (!found && vld8[idx[2:0]]) begin
            found = 1'b1;
            win   = idx[2:0];
         end
      end
   end

   assign grant_ok = (state_q == IDLE) && !bus.TX_BUSY && found;

   assign bus.REQ_READY = grant_ok ? N_REQ'(8'd1 << win) : '0;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pen_d   = pen_q;
      ptyp_d  = ptyp_q;
      dv_d    = dv_q;
      gid_d   = gid_q;
      last_d  = last_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (grant_ok) begin
               state_d = ISSUE;
               data_d  = data64[{win, 3'b000} +: 8];
               pen_d   = pen8[win];
               ptyp_d  = ptyp8[win];
               dv_d    = 1'b1;
               gid_d   = win;
               last_d  = win;
            end
         end
         ISSUE: begin
            if (bus.TX_BUSY) begin
               dv_d    = 1'b0;
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.TX_BUSY) begin
               if (MIN_GAP > 0) begin
                  state_d = GAP;
                  gap_d   = 8'(MIN_GAP - 1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_q == 8'd0) state_d = IDLE;
            else               gap_d   = gap_q - 8'd1;
         end
         default: begin
            state_d = IDLE;
            dv_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         data_q  <= 8'd0;
         pen_q   <= 1'b0;
         ptyp_q  <= 1'b0;
         dv_q    <= 1'b0;
         gid_q   <= 3'd0;
         last_q  <= 3'(N_REQ - 1);
         gap_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         pen_q   <= pen_d;
         ptyp_q  <= ptyp_d;
         dv_q    <= dv_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
      end
   end

   assign bus.P_DATA     = data_q;
   assign bus.PAR_EN     = pen_q;
   assign bus.PAR_TYP    = ptyp_q;
   assign bus.DATA_VALID = dv_q;
   assign bus.GRANT_ID   = gid_q;
   assign bus.ACTIVE     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed phases plus random traffic,
// checked every cycle against a frame-level reference model.
module tb_uart_tx_arbiter;
   localparam int N     = 4;
   localparam int G     = 3;
   localparam int FRAME = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .MIN_GAP(G)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [N-1:0] r_valid;
   logic [7:0]   r_data [N];
   logic [N-1:0] r_pen;
   logic [N-1:0] r_ptyp;
   logic         r_rst;
   logic         force_busy;
   int           tx_cnt;

   // reference model: frame owned, start strobe pending, gap cycles left
   bit         m_known;
   bit         m_frame;
   bit         m_dv;
   int         m_gap;
   int         m_last;
   int         m_gid;
   logic [7:0] m_pd;
   logic       m_pe;
   logic       m_pt;
   bit         acc;
   int         acc_id;
   int         grants[$];

   function automatic int pick(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int w;
      bit busy;
      logic [N-1:0] e_rdy;
      @(negedge clk);
      rst = r_rst;
      bus.REQ_VALID   = r_valid;
      bus.REQ_PAR_EN  = r_pen;
      bus.REQ_PAR_TYP = r_ptyp;
      for (int i = 0; i < N; i++) bus.REQ_DATA[8*i +: 8] = r_data[i];
      bus.TX_BUSY = (tx_cnt > 0) || force_busy;
      busy = bus.TX_BUSY;
      #1;
      w = pick(r_valid, m_last);
      e_rdy = '0;
      if (!m_frame && m_gap == 0 && !busy && w >= 0) e_rdy[w] = 1'b1;
      if (m_known) begin
         chk("ready",  32'(bus.REQ_READY),  32'(e_rdy));
         chk("dvalid", 32'(bus.DATA_VALID), 32'(m_dv));
         chk("pdata",  32'(bus.P_DATA),     32'(m_pd));
         chk("par_en", 32'(bus.PAR_EN),     32'(m_pe));
         chk("par_ty", 32'(bus.PAR_TYP),    32'(m_pt));
         chk("grant",  32'(bus.GRANT_ID),   32'(m_gid));
         chk("active", 32'(bus.ACTIVE),     32'(m_frame || m_gap > 0));
      end
      acc = 1'b0;
      if (r_rst) begin
         m_known = 1; m_frame = 0; m_dv = 0; m_gap = 0;
         m_last = N - 1; m_gid = 0; m_pd = '0; m_pe = 0; m_pt = 0;
      end else if (!m_frame && m_gap == 0) begin
         if (!busy && w >= 0) begin
            acc = 1'b1; acc_id = w; grants.push_back(w);
            m_pd = r_data[w]; m_pe = r_pen[w]; m_pt = r_ptyp[w];
            m_gid = w; m_last = w; m_frame = 1; m_dv = 1;
         end
      end else if (m_frame && m_dv) begin
         if (busy) m_dv = 0;
      end else if (m_frame) begin
         if (!busy) begin m_frame = 0; m_gap = G; end
      end else begin
         m_gap--;
      end
      if (tx_cnt > 0) tx_cnt--;
      else if (bus.DATA_VALID === 1'b1) tx_cnt = FRAME;
   endtask

   task automatic serve(int n, bit keep);
      int got = 0;
      for (int c = 0; c < 400 && got < n; c++) begin
         step();
         if (acc) begin
            got++;
            if (keep) begin
               r_data[acc_id] = 8'($urandom);
               r_pen[acc_id]  = 1'($urandom);
               r_ptyp[acc_id] = 1'($urandom);
            end else begin
               r_valid[acc_id] = 1'b0;
            end
         end
      end
      chk("serve_count", 32'(got), 32'(n));
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         step();
         done = !m_frame && m_gap == 0 && tx_cnt == 0;
      end
      chk("idle_reached", 32'(done), 32'd1);
   endtask

   initial begin
      bit hit;
      rst = 1'b1;
      r_rst = 1'b1; r_valid = '0; r_pen = '0; r_ptyp = '0;
      for (int i = 0; i < N; i++) r_data[i] = '0;
      force_busy = 1'b0; tx_cnt = 0; m_known = 0;
      m_frame = 0; m_dv = 0; m_gap = 0; m_last = N - 1; m_gid = 0;
      m_pd = '0; m_pe = 0; m_pt = 0;
      repeat (2) step();
      r_rst = 1'b0;
      step();
      chk("rst_grant", 32'(bus.GRANT_ID), 32'd0);
      chk("rst_active", 32'(bus.ACTIVE), 32'd0);

      // single requester 1, 0xA5, even parity
      grants.delete();
      r_valid = 4'b0010; r_data[1] = 8'hA5; r_pen[1] = 1; r_ptyp[1] = 0;
      serve(1, 0);
      step();
      chk("single_pdata", 32'(bus.P_DATA), 32'hA5);
      chk("single_gid", 32'(bus.GRANT_ID), 32'd1);
      wait_idle();

      // round robin from reset, all requesting
      r_rst = 1'b1; step(); r_rst = 1'b0;
      for (int i = 0; i < N; i++) r_data[i] = 8'($urandom);
      r_pen = 4'($urandom); r_ptyp = 4'($urandom);
      grants.delete();
      r_valid = '1;
      serve(8, 1);
      r_valid = '0;
      wait_idle();
      for (int i = 0; i < 8; i++)
         chk($sformatf("rr_seq%0d", i), 32'(grants[i]), 32'(i % N));

      // priority after last grant 2
      r_valid = 4'b0100;
      serve(1, 0);
      wait_idle();
      grants.delete();
      r_valid = 4'b1001;
      serve(2, 0);
      wait_idle();
      chk("prio_first", 32'(grants[0]), 32'd3);
      chk("prio_second", 32'(grants[1]), 32'd0);

      // transmitter held busy
      force_busy = 1'b1;
      r_valid = 4'b0001;
      repeat (20) step();
      force_busy = 1'b0;
      serve(1, 0);
      wait_idle();

      // random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) r_valid = N'($urandom);
         for (int i = 0; i < N; i++)
            if ($urandom_range(1) == 0) r_data[i] = 8'($urandom);
         r_pen = N'($urandom); r_ptyp = N'($urandom);
         step();
      end
      r_valid = '0;
      wait_idle();

      // reset pulsed while waiting for the frame to finish
      r_valid = 4'b0100;
      serve(1, 0);
      hit = 0;
      for (int c = 0; c < 50 && !hit; c++) begin
         step();
         hit = m_frame && !m_dv;
      end
      chk("reached_wait", 32'(hit), 32'd1);
      r_rst = 1'b1; step(); r_rst = 1'b0;
      step();
      chk("mid_rst_active", 32'(bus.ACTIVE), 32'd0);
      chk("mid_rst_pdata", 32'(bus.P_DATA), 32'd0);
      grants.delete();
      r_valid = '1;
      serve(1, 0);
      r_valid = '0;
      wait_idle();
      chk("mid_rst_next", 32'(grants[0]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `N_REQ` byte-level requesters. Each requester offers a byte plus its own parity configuration over a valid/ready handshake. The arbiter latches one winner and drives the transmitter's `P_DATA`/`PAR_EN`/`PAR_TYP`/`DATA_VALID` inputs. It holds that configuration stable for the whole frame by tracking the transmitter's `Busy`. It sits directly in front of the UART transmitter in the TX path.

## Interface
- `N_REQ`, default 4, number of requesters (2..8).
- `MIN_GAP`, default 0, extra idle cycles inserted after the transmitter goes idle and before the next grant (0..255).
- `CLK`  in  1  clock.
- `RST`  in  1  reset, synchronous, active-high.
- `REQ_VALID`  in  N_REQ  requester i has a byte to send; held until accepted.
- `REQ_DATA`  in  8*N_REQ  byte of requester i in bits [8i+7:8i].
- `REQ_PAR_EN`  in  N_REQ  parity enable for requester i.
- `REQ_PAR_TYP`  in  N_REQ  parity type for requester i (0 even, 1 odd).
- `REQ_READY`  out  N_REQ  one-hot accept strobe (combinational); transfer when `REQ_VALID[i]` and `REQ_READY[i]` are both 1.
- `TX_BUSY`  in  1  transmitter Busy.
- `P_DATA`  out  8  byte to transmitter (registered).
- `PAR_EN`  out  1  parity enable to transmitter (registered).
- `PAR_TYP`  out  1  parity type to transmitter (registered).
- `DATA_VALID`  out  1  start request to transmitter (registered).
- `GRANT_ID`  out  3  index of the requester owning the current or last frame (registered).
- `ACTIVE`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- **IDLE**
  - If `TX_BUSY`=0 and any `REQ_VALID` is set, assert `REQ_READY` for the round-robin winner only.
  - The search starts at index `(last_grant+1) mod N_REQ` and wraps.
  - On the accepting edge, latch the winner's data, `PAR_EN` and `PAR_TYP`; set `GRANT_ID`/`last_grant`; set `DATA_VALID`<=1; go to ISSUE.
  - If `TX_BUSY`=1 in IDLE, no grant is made and `REQ_READY`=0.
- **ISSUE**
  - `DATA_VALID` stays high until `TX_BUSY`=1 is sampled.
  - On that edge, clear `DATA_VALID` and go to WAIT_DONE.
  - `REQ_READY`=0.
- **WAIT_DONE**
  - Hold `P_DATA`, `PAR_EN` and `PAR_TYP` unchanged.
  - When `TX_BUSY`=0 is sampled: go to GAP, loading the gap counter with `MIN_GAP-1`, if `MIN_GAP`>0; otherwise go to IDLE.
- **GAP**
  - Decrement the counter each cycle and go to IDLE when it reaches 0, giving exactly `MIN_GAP` cycles in GAP.
- `P_DATA`, `PAR_EN` and `PAR_TYP` change only on an accepting edge. Between frames they keep the last frame's values.
- `REQ_VALID` may drop without acceptance; a dropped request loses nothing and does not move the pointer.
- Invalid/unused state codes go to IDLE with `DATA_VALID`=0.
- **Reset** (takes effect at any state, including mid-frame)
  - State IDLE; `P_DATA`=0, `PAR_EN`=0, `PAR_TYP`=0, `DATA_VALID`=0, `GRANT_ID`=0, gap counter=0.
  - `last_grant`=`N_REQ-1`, so requester 0 has first priority.
  - A transmitter frame already in flight is not aborted by the arbiter. After reset it honours the IDLE rule: no grant while `TX_BUSY`=1.

## Timing
- Accept at edge t; `DATA_VALID`=1 during cycle t+1.
- The transmitter leaves its idle state at edge t+2, so `TX_BUSY`=1 during t+2.
- `DATA_VALID` is cleared at edge t+3, giving 2 cycles of `DATA_VALID` with a compliant transmitter.
- The earliest next accept is the first cycle after WAIT_DONE samples `TX_BUSY`=0, plus `MIN_GAP` cycles.
- With `MIN_GAP`=0 there is 1 cycle of arbiter overhead between transmitter idle and the next `DATA_VALID`: cycle t' IDLE accept, cycle t'+1 `DATA_VALID`.
- At most one `REQ_READY` bit is high in any cycle, and only in IDLE.

## Test plan
- **Single requester.** Requester 1 sends 0xA5 with parity even, `MIN_GAP`=0.
  - `REQ_READY`=4'b0010 for one cycle; `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0; `DATA_VALID` is high for 2 cycles; `GRANT_ID`=1.
  - The serial line shows start, data, parity bit 0, stop.
- **Round-robin order.** All four `REQ_VALID` held high after reset, 8 frames.
  - `GRANT_ID` sequence is 0,1,2,3,0,1,2,3, with no two `REQ_READY` bits set in any cycle.
- **Priority after last grant.** Last grant was 2; requesters 0 and 3 both request.
  - Requester 3 is granted first, then requester 0.
- **Transmitter busy.** `TX_BUSY` forced high for 20 cycles with `REQ_VALID`=4'b0001.
  - `REQ_READY` stays 0 and `DATA_VALID` stays 0; the grant occurs in the first cycle after `TX_BUSY` is sampled low.
- **Inter-frame gap.** `MIN_GAP`=3, two back-to-back requests.
  - Exactly 3 GAP cycles plus 1 accept cycle separate transmitter idle from the second `DATA_VALID`; `P_DATA` is stable throughout each frame.
- **Reset mid-frame.** `RST` pulsed during WAIT_DONE.
  - All outputs return to their reset values the next cycle; `ACTIVE`=0; the next grant goes to requester 0 once `TX_BUSY`=0.
